// File: rtl/operand_fetch_stage_pkg.sv
// Shared types for the decode->execute boundary: register names, forwarding
// selects and the ID/EX pipeline register layout.
package operand_fetch_stage_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [4:0] {
    X0,  X1,  X2,  X3,  X4,  X5,  X6,  X7,
    X8,  X9,  X10, X11, X12, X13, X14, X15,
    X16, X17, X18, X19, X20, X21, X22, X23,
    X24, X25, X26, X27, X28, X29, X30, X31
  } reg_e;

  typedef logic [DEF_XLEN-1:0] word_st;

  typedef enum logic [1:0] {
    FWD_ZERO,
    FWD_MEM,
    FWD_WB,
    FWD_RF
  } fwd_sel_e;

  typedef struct packed {
    word_st pc;
    word_st imm;
    word_st rs1_d;
    word_st rs2_d;
    reg_e   rd_a;
    logic   is_load;
  } id_ex_st;

  // x0 never creates a dependency, and unused sources are ignored.
  function automatic logic reg_match(reg_e rs, logic use_rs);
    return use_rs && (rs != X0);
  endfunction

endpackage

// File: rtl/operand_fetch_stage_if.sv
// Bundle of decode, regfile, MEM/WB bypass and execute-side signals around the
// operand fetch stage. The stage itself connects through the slave modport.
interface operand_fetch_stage_if
  import operand_fetch_stage_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int CNT_W = DEF_CNT_W
);

  logic             flush_i;
  logic             id_valid_i;
  logic             id_ready_o;
  logic [XLEN-1:0]  id_pc_i;
  logic [XLEN-1:0]  id_imm_i;
  reg_e             id_rs1_a_i;
  reg_e             id_rs2_a_i;
  reg_e             id_rd_a_i;
  logic             id_use_rs1_i;
  logic             id_use_rs2_i;
  logic             id_is_load_i;

  reg_e             rf_rs1_a_o;
  reg_e             rf_rs2_a_o;
  logic [XLEN-1:0]  rf_rs1_d_i;
  logic [XLEN-1:0]  rf_rs2_d_i;

  logic             mem_we_i;
  logic             mem_is_load_i;
  reg_e             mem_rd_a_i;
  logic [XLEN-1:0]  mem_rd_d_i;
  logic             wb_we_i;
  reg_e             wb_rd_a_i;
  logic [XLEN-1:0]  wb_rd_d_i;

  logic             ex_valid_o;
  logic             ex_ready_i;
  logic [XLEN-1:0]  ex_pc_o;
  logic [XLEN-1:0]  ex_imm_o;
  logic [XLEN-1:0]  ex_rs1_d_o;
  logic [XLEN-1:0]  ex_rs2_d_o;
  reg_e             ex_rd_a_o;
  logic             ex_is_load_o;
  logic [CNT_W-1:0] bubble_cnt_o;

  modport slave (
    input  flush_i, id_valid_i, id_pc_i, id_imm_i, id_rs1_a_i, id_rs2_a_i,
           id_rd_a_i, id_use_rs1_i, id_use_rs2_i, id_is_load_i,
           rf_rs1_d_i, rf_rs2_d_i,
           mem_we_i, mem_is_load_i, mem_rd_a_i, mem_rd_d_i,
           wb_we_i, wb_rd_a_i, wb_rd_d_i, ex_ready_i,
    output id_ready_o, rf_rs1_a_o, rf_rs2_a_o,
           ex_valid_o, ex_pc_o, ex_imm_o, ex_rs1_d_o, ex_rs2_d_o,
           ex_rd_a_o, ex_is_load_o, bubble_cnt_o
  );

  modport master (
    output flush_i, id_valid_i, id_pc_i, id_imm_i, id_rs1_a_i, id_rs2_a_i,
           id_rd_a_i, id_use_rs1_i, id_use_rs2_i, id_is_load_i,
           rf_rs1_d_i, rf_rs2_d_i,
           mem_we_i, mem_is_load_i, mem_rd_a_i, mem_rd_d_i,
           wb_we_i, wb_rd_a_i, wb_rd_d_i, ex_ready_i,
    input  id_ready_o, rf_rs1_a_o, rf_rs2_a_o,
           ex_valid_o, ex_pc_o, ex_imm_o, ex_rs1_d_o, ex_rs2_d_o,
           ex_rd_a_o, ex_is_load_o, bubble_cnt_o
  );

endinterface

// File: rtl/operand_fetch_stage_bypass.sv
// Per-operand forwarding: picks MEM, WB, regfile or zero for one source
// register and flags a load-use dependency that no bypass can satisfy yet.
module operand_bypass
  import operand_fetch_stage_pkg::*;
#(
  parameter int XLEN = DEF_XLEN
) (
  input  reg_e            rs_a,
  input  logic            use_rs,
  input  logic [XLEN-1:0] rf_d,
  input  logic            ex_valid,
  input  logic            ex_is_load,
  input  reg_e            ex_rd_a,
  input  logic            mem_we,
  input  logic            mem_is_load,
  input  reg_e            mem_rd_a,
  input  logic [XLEN-1:0] mem_rd_d,
  input  logic            wb_we,
  input  reg_e            wb_rd_a,
  input  logic [XLEN-1:0] wb_rd_d,
  output logic [XLEN-1:0] data,
  output logic            hazard
);

  fwd_sel_e sel;

  // A load sitting in MEM has no data yet, so it never wins the MEM slot;
  // the hazard below holds the instruction until the value reaches WB.
  always_comb begin
    sel = FWD_RF;
    if (rs_a == X0) begin
      sel = FWD_ZERO;
    end else if (mem_we && !mem_is_load && (mem_rd_a == rs_a)) begin
      sel = FWD_MEM;
    end else if (wb_we && (wb_rd_a == rs_a)) begin
      sel = FWD_WB;
    end
  end

  always_comb begin
    data = '0;
    case (sel)
      FWD_ZERO: data = '0;
      FWD_MEM:  data = mem_rd_d;
      FWD_WB:   data = wb_rd_d;
      FWD_RF:   data = rf_d;
      default:  data = '0;
    endcase
  end

  always_comb begin
    hazard = 1'b0;
    if (reg_match(rs_a, use_rs)) begin
      hazard = (ex_valid && ex_is_load && (ex_rd_a == rs_a)) ||
               (mem_we && mem_is_load && (mem_rd_a == rs_a));
    end
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// Decode->execute boundary: bypassed operand fetch into a valid/ready ID/EX
// register with load-use bubble insertion, flush and a saturating bubble count.
module operand_fetch_stage
  import operand_fetch_stage_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  operand_fetch_stage_if.slave  bus
);

  localparam int NUM_SRC = 2;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  reg_e            src_a   [NUM_SRC];
  logic            src_use [NUM_SRC];
  logic [XLEN-1:0] src_rf  [NUM_SRC];
  logic [XLEN-1:0] src_d   [NUM_SRC];
  logic            src_hz  [NUM_SRC];

  id_ex_st          ex_q, ex_d;
  logic             ex_valid_q, ex_valid_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  logic load_en;
  logic hazard;

  assign src_a[0]   = bus.id_rs1_a_i;
  assign src_a[1]   = bus.id_rs2_a_i;
  assign src_use[0] = bus.id_use_rs1_i;
  assign src_use[1] = bus.id_use_rs2_i;
  assign src_rf[0]  = bus.rf_rs1_d_i;
  assign src_rf[1]  = bus.rf_rs2_d_i;

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      operand_bypass #(
        .XLEN(XLEN)
      ) u_bypass (
        .rs_a        (src_a[gi]),
        .use_rs      (src_use[gi]),
        .rf_d        (src_rf[gi]),
        .ex_valid    (ex_valid_q),
        .ex_is_load  (ex_q.is_load),
        .ex_rd_a     (ex_q.rd_a),
        .mem_we      (bus.mem_we_i),
        .mem_is_load (bus.mem_is_load_i),
        .mem_rd_a    (bus.mem_rd_a_i),
        .mem_rd_d    (bus.mem_rd_d_i),
        .wb_we       (bus.wb_we_i),
        .wb_rd_a     (bus.wb_rd_a_i),
        .wb_rd_d     (bus.wb_rd_d_i),
        .data        (src_d[gi]),
        .hazard      (src_hz[gi])
      );
    end
  endgenerate

  assign hazard  = src_hz[0] || src_hz[1];
  assign load_en = !ex_valid_q || bus.ex_ready_i;

  // Bubbles leave the payload untouched so downstream sees no toggling.
  always_comb begin
    ex_d         = ex_q;
    ex_valid_d   = ex_valid_q;
    bubble_cnt_d = bubble_cnt_q;
    if (bus.flush_i) begin
      ex_valid_d = 1'b0;
    end else if (load_en) begin
      if (!bus.id_valid_i) begin
        ex_valid_d = 1'b0;
      end else if (hazard) begin
        ex_valid_d = 1'b0;
        if (bubble_cnt_q != '1) begin
          bubble_cnt_d = bubble_cnt_q + CNT_ONE;
        end
      end else begin
        ex_valid_d    = 1'b1;
        ex_d.pc       = bus.id_pc_i;
        ex_d.imm      = bus.id_imm_i;
        ex_d.rs1_d    = src_d[0];
        ex_d.rs2_d    = src_d[1];
        ex_d.rd_a     = bus.id_rd_a_i;
        ex_d.is_load  = bus.id_is_load_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_q         <= '0;
      ex_valid_q   <= 1'b0;
      bubble_cnt_q <= '0;
    end else begin
      ex_q         <= ex_d;
      ex_valid_q   <= ex_valid_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bus.id_ready_o   = bus.flush_i || (load_en && !hazard);
  assign bus.rf_rs1_a_o   = bus.id_rs1_a_i;
  assign bus.rf_rs2_a_o   = bus.id_rs2_a_i;
  assign bus.ex_valid_o   = ex_valid_q;
  assign bus.ex_pc_o      = ex_q.pc;
  assign bus.ex_imm_o     = ex_q.imm;
  assign bus.ex_rs1_d_o   = ex_q.rs1_d;
  assign bus.ex_rs2_d_o   = ex_q.rs2_d;
  assign bus.ex_rd_a_o    = ex_q.rd_a;
  assign bus.ex_is_load_o = ex_q.is_load;
  assign bus.bubble_cnt_o = bubble_cnt_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage: a rule-level pipeline model checked
// every cycle, plus hand-computed literal checks for each scenario.
module tb_operand_fetch_stage;
  import operand_fetch_stage_pkg::*;

  localparam int CNT_MAX = 65535;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  operand_fetch_stage_if #(.XLEN(32), .CNT_W(16)) bus ();

  operand_fetch_stage #(.XLEN(32), .CNT_W(16)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_valid;
  logic [31:0] m_pc, m_imm, m_op1, m_op2;
  int          m_rd;
  bit          m_ld;
  int          m_cnt;

  function automatic reg_e r(input int n);
    logic [4:0] v;
    v = n[4:0];
    return reg_e'(v);
  endfunction

  function automatic logic [31:0] fwd(input int rs, input logic [31:0] rf);
    if (rs == 0) return 32'h0;
    if (bus.mem_we_i && !bus.mem_is_load_i && int'(bus.mem_rd_a_i) == rs) return bus.mem_rd_d_i;
    if (bus.wb_we_i && int'(bus.wb_rd_a_i) == rs) return bus.wb_rd_d_i;
    return rf;
  endfunction

  function automatic bit waits_on(input int rs, input bit used);
    if (!used || rs == 0) return 1'b0;
    return (m_valid && m_ld && m_rd == rs) ||
           (bus.mem_we_i && bus.mem_is_load_i && int'(bus.mem_rd_a_i) == rs);
  endfunction

  function automatic bit m_hazard();
    return waits_on(int'(bus.id_rs1_a_i), bus.id_use_rs1_i) ||
           waits_on(int'(bus.id_rs2_a_i), bus.id_use_rs2_i);
  endfunction

  function automatic bit m_accept();
    return bus.flush_i || ((!m_valid || bus.ex_ready_i) && !m_hazard());
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 0; m_pc = 0; m_imm = 0; m_op1 = 0; m_op2 = 0;
      m_rd = 0; m_ld = 0; m_cnt = 0;
    end else if (bus.flush_i) begin
      m_valid = 0;
    end else if (!m_valid || bus.ex_ready_i) begin
      if (!bus.id_valid_i) begin
        m_valid = 0;
      end else if (m_hazard()) begin
        m_valid = 0;
        if (m_cnt < CNT_MAX) m_cnt++;
      end else begin
        m_op1   = fwd(int'(bus.id_rs1_a_i), bus.rf_rs1_d_i);
        m_op2   = fwd(int'(bus.id_rs2_a_i), bus.rf_rs2_d_i);
        m_pc    = bus.id_pc_i;
        m_imm   = bus.id_imm_i;
        m_rd    = int'(bus.id_rd_a_i);
        m_ld    = bus.id_is_load_i;
        m_valid = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("ex_valid",   bus.ex_valid_o,   m_valid);
      chk("ex_pc",      bus.ex_pc_o,      m_pc);
      chk("ex_imm",     bus.ex_imm_o,     m_imm);
      chk("ex_rs1_d",   bus.ex_rs1_d_o,   m_op1);
      chk("ex_rs2_d",   bus.ex_rs2_d_o,   m_op2);
      chk("ex_rd_a",    bus.ex_rd_a_o,    m_rd);
      chk("ex_is_load", bus.ex_is_load_o, m_ld);
      chk("bubble_cnt", bus.bubble_cnt_o, m_cnt);
      chk("id_ready",   bus.id_ready_o,   m_accept());
      chk("rf_rs1_a",   bus.rf_rs1_a_o,   bus.id_rs1_a_i);
      chk("rf_rs2_a",   bus.rf_rs2_a_o,   bus.id_rs2_a_i);
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    bus.flush_i = 0; bus.id_valid_i = 0; bus.id_pc_i = 0; bus.id_imm_i = 0;
    bus.id_rs1_a_i = X0; bus.id_rs2_a_i = X0; bus.id_rd_a_i = X0;
    bus.id_use_rs1_i = 0; bus.id_use_rs2_i = 0; bus.id_is_load_i = 0;
    bus.rf_rs1_d_i = 0; bus.rf_rs2_d_i = 0;
    bus.mem_we_i = 0; bus.mem_is_load_i = 0; bus.mem_rd_a_i = X0; bus.mem_rd_d_i = 0;
    bus.wb_we_i = 0; bus.wb_rd_a_i = X0; bus.wb_rd_d_i = 0;
    bus.ex_ready_i = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] pc, input int rs1, input bit u1,
                       input int rs2, input bit u2, input int rd, input bit ld);
    bus.id_valid_i = 1; bus.id_pc_i = pc; bus.id_imm_i = pc ^ 32'h0000_0F0F;
    bus.id_rs1_a_i = r(rs1); bus.id_use_rs1_i = u1;
    bus.id_rs2_a_i = r(rs2); bus.id_use_rs2_i = u2;
    bus.id_rd_a_i = r(rd); bus.id_is_load_i = ld;
  endtask

  initial begin
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("reset_valid", bus.ex_valid_o, 1'b0);
    chk("reset_cnt",   bus.bubble_cnt_o, 16'h0);
    chk("reset_pc",    bus.ex_pc_o, 32'h0);

    // WB bypass over stale regfile data
    offer(32'h100, 5, 1, 6, 1, 8, 0);
    bus.wb_we_i = 1; bus.wb_rd_a_i = X5; bus.wb_rd_d_i = 32'hDEAD_BEEF;
    bus.rf_rs1_d_i = 32'h0; bus.rf_rs2_d_i = 32'h66;
    tick();
    $display("txn wb_bypass pc=%h rs1_d=%h rs2_d=%h", bus.ex_pc_o, bus.ex_rs1_d_o, bus.ex_rs2_d_o);
    chk("wb_bypass_rs1", bus.ex_rs1_d_o, 32'hDEAD_BEEF);
    chk("wb_bypass_rs2", bus.ex_rs2_d_o, 32'h66);

    // MEM beats WB; x0 always reads zero
    offer(32'h104, 7, 1, 0, 1, 9, 0);
    bus.mem_we_i = 1; bus.mem_rd_a_i = X7; bus.mem_rd_d_i = 32'h11;
    bus.wb_we_i = 1; bus.wb_rd_a_i = X7; bus.wb_rd_d_i = 32'h22;
    bus.rf_rs1_d_i = 32'h33; bus.rf_rs2_d_i = 32'h99;
    tick();
    $display("txn mem_prio pc=%h rs1_d=%h rs2_d=%h", bus.ex_pc_o, bus.ex_rs1_d_o, bus.ex_rs2_d_o);
    chk("mem_over_wb", bus.ex_rs1_d_o, 32'h11);
    chk("x0_zero",     bus.ex_rs2_d_o, 32'h0);
    offer(32'h108, 7, 1, 0, 1, 9, 0);
    bus.mem_rd_a_i = X0; bus.mem_rd_d_i = 32'h55; bus.rf_rs2_d_i = 32'h77;
    tick();
    $display("txn x0_mem pc=%h rs1_d=%h rs2_d=%h", bus.ex_pc_o, bus.ex_rs1_d_o, bus.ex_rs2_d_o);
    chk("x0_vs_mem_x0", bus.ex_rs2_d_o, 32'h0);
    chk("wb_when_mem_other", bus.ex_rs1_d_o, 32'h22);
    idle();

    // Load-use: one bubble, then issue with the WB value
    offer(32'h200, 1, 0, 0, 0, 3, 1);
    tick();
    offer(32'h204, 3, 1, 0, 0, 4, 0);
    bus.rf_rs1_d_i = 32'h1;
    #1 chk("loaduse_stall_ready", bus.id_ready_o, 1'b0);
    tick();
    $display("txn load_use_bubble valid=%0d cnt=%0d", bus.ex_valid_o, bus.bubble_cnt_o);
    chk("loaduse_bubble", bus.ex_valid_o, 1'b0);
    chk("loaduse_cnt",    bus.bubble_cnt_o, 16'd1);
    bus.wb_we_i = 1; bus.wb_rd_a_i = X3; bus.wb_rd_d_i = 32'hCAFE_0003;
    #1 chk("loaduse_wb_ready", bus.id_ready_o, 1'b1);
    tick();
    $display("txn load_use_issue pc=%h rs1_d=%h", bus.ex_pc_o, bus.ex_rs1_d_o);
    chk("loaduse_issue_pc",  bus.ex_pc_o, 32'h204);
    chk("loaduse_issue_rs1", bus.ex_rs1_d_o, 32'hCAFE_0003);
    idle();

    // Backpressure: hold for four cycles, then exactly one transfer
    bus.ex_ready_i = 0;
    offer(32'h300, 0, 0, 0, 0, 10, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      $display("txn backpressure cycle=%0d pc=%h ready=%0d", i, bus.ex_pc_o, bus.id_ready_o);
      chk("bp_hold_pc", bus.ex_pc_o, 32'h204);
      chk("bp_ready",   bus.id_ready_o, 1'b0);
    end
    bus.ex_ready_i = 1;
    tick();
    $display("txn backpressure_release pc=%h", bus.ex_pc_o);
    chk("bp_release_pc", bus.ex_pc_o, 32'h300);
    bus.id_valid_i = 0;
    tick();
    chk("bp_drain", bus.ex_valid_o, 1'b0);

    // Asynchronous reset between edges clears an in-flight instruction
    offer(32'h400, 0, 0, 0, 0, 11, 0);
    tick();
    chk("pre_reset_valid", bus.ex_valid_o, 1'b1);
    #2 rst = 1;
    #1;
    $display("txn async_reset valid=%0d cnt=%0d", bus.ex_valid_o, bus.bubble_cnt_o);
    chk("async_reset_valid", bus.ex_valid_o, 1'b0);
    chk("async_reset_cnt",   bus.bubble_cnt_o, 16'd0);
    @(posedge clk);
    #1 rst = 0;
    idle();
    tick();

    // Flush wins over a hazard: instruction dropped, no count
    offer(32'h500, 0, 0, 0, 0, 3, 1);
    tick();
    offer(32'h504, 3, 1, 0, 0, 5, 0);
    bus.flush_i = 1;
    #1 chk("flush_ready", bus.id_ready_o, 1'b1);
    tick();
    $display("txn flush valid=%0d cnt=%0d", bus.ex_valid_o, bus.bubble_cnt_o);
    chk("flush_valid", bus.ex_valid_o, 1'b0);
    chk("flush_cnt",   bus.bubble_cnt_o, 16'd0);
    bus.flush_i = 0;

    // Saturation: a load stuck in MEM keeps the offered instruction stalled
    bus.mem_we_i = 1; bus.mem_is_load_i = 1; bus.mem_rd_a_i = X3; bus.mem_rd_d_i = 32'hBAD0_BAD0;
    repeat (10) tick();
    chk("sat_partial", bus.bubble_cnt_o, 16'd10);
    repeat (CNT_MAX) tick();
    $display("txn saturate cnt=%h valid=%0d", bus.bubble_cnt_o, bus.ex_valid_o);
    chk("sat_cnt",   bus.bubble_cnt_o, 16'hFFFF);
    chk("sat_valid", bus.ex_valid_o, 1'b0);

    idle();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
